alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE, default 1, meaning: ALU operand hold cycles before result capture; legal range 1..4.
REQ-002 Reset and clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N operation this cycle.
REQ-007 reqN_a, reqN_b  input  4 each  operands of requester N.
REQ-008 reqN_op  input  2  opcode: 00 AND, 10 OR, 01 ADD, 11 SUB.
REQ-009 rspN_valid  output  1  result for requester N is available.
REQ-010 rspN_ready  input  1  requester N consumes the result.
REQ-011 rspN_r  output  5  captured ALU result for requester N.
REQ-012 rspN_neg  output  1  captured negative flag for requester N.
REQ-013 alu_a, alu_b  output  4 each  operands driven to the shared ALU.
REQ-014 alu_op  output  2  opcode driven to the shared ALU.
REQ-015 alu_r  input  5  ALU result; alu_neg  input  1  ALU negative flag.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; transitions only as REQ-018..REQ-024.
REQ-018 IDLE: grant = the requester with valid high; both valid -> the one not granted last (round-robin pointer); reqN_ready = IDLE and grant==N, combinational.
REQ-019 Accept edge (valid&&ready): latch a, b, op, grant ID; load cnt=SETTLE-1; go EXEC; pointer updates to the granted ID.
REQ-020 EXEC: alu_a/alu_b/alu_op driven from latched registers, stable for exactly SETTLE cycles; cnt decrements each cycle.
REQ-021 Edge with EXEC and cnt==0: capture alu_r into granted rspN_r; capture rspN_neg = alu_neg if latched op==11 else 0; go RESP.
REQ-022 RESP: only granted rspN_valid high; rspN_r/rspN_neg stable until handshake; both reqN_ready low.
REQ-023 RESP with rspN_ready high: rspN_valid falls next edge; go IDLE; no accept in that same cycle.
REQ-024 Latency: rspN_valid high SETTLE cycles after accept edge; minimum initiation interval SETTLE+2 cycles.
REQ-025 alu_a/alu_b/alu_op SHALL hold last latched values outside EXEC (no glitching to requester inputs).
REQ-026 Requester inputs changing during EXEC/RESP SHALL have no effect on the operation in flight.
REQ-027 Non-granted rsp outputs SHALL keep their last captured values with rspN_valid low.
REQ-028 Pointer after reset SHALL favour requester 0 on first simultaneous request.
REQ-029 rspN_ready asserted while rspN_valid low SHALL be ignored.

Reset
REQ-030 rst high at any edge SHALL force IDLE, cnt=0, pointer to favour req0, all ready/valid/busy low, rsp*_r=0, rsp*_neg=0, alu_a=alu_b=0, alu_op=00.
REQ-031 rst during EXEC or RESP SHALL abort the operation; no response is ever delivered for it.
REQ-032 First accept possible in the first cycle with rst low.

Verification
REQ-033 req0 valid, a=5, b=3, op=01, SETTLE=1 -> req0_ready same cycle; next cycle rsp0_valid=1, rsp0_r=8, rsp0_neg=0.
REQ-034 req1 a=3, b=5, op=11 -> rsp1_r=5'b11110, rsp1_neg=1; a=5, b=3, op=11 -> rsp1_r=5'b00010 (borrow-complement form), rsp1_neg=0.
REQ-035 Both valid continuously after reset -> grants alternate 0,1,0,1; each rsp on matching port only.
REQ-036 rsp0_ready held low 10 cycles -> rsp0_valid and rsp0_r stable throughout; req1 not accepted until handshake plus one IDLE cycle.
REQ-037 rst asserted in EXEC (SETTLE=4, cycle 2) -> next cycle IDLE, all outputs at REQ-030 values, no rsp_valid pulse.
REQ-038 op=00 a=12 b=10 with alu_neg forced 1 -> rsp_r=8, rsp_neg=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared external ALU.
// Each accepted operation holds the ALU operands for SETTLE cycles, then its result is held until consumed.
module alu_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [4:0] rsp0_r,
  output logic       rsp0_neg,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [4:0] rsp1_r,
  output logic       rsp1_neg,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [4:0] alu_r,
  input  logic       alu_neg,
  output logic       busy
);

  localparam logic [1:0] CNT_INIT = 2'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_last;
  logic       r_gid;
  logic [1:0] r_cnt;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [1:0] r_op;
  logic [4:0] r_rsp0_r;
  logic [4:0] r_rsp1_r;
  logic       r_rsp0_neg;
  logic       r_rsp1_neg;
  logic       w_grant;
  logic       w_accept;
  logic       w_cap;

  // The ALU negative flag is only meaningful for subtraction.
  function automatic logic neg_flag(input logic [1:0] op, input logic neg);
    return (op == 2'b11) ? neg : 1'b0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_cap      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    w_grant    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    case (r_state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = ~w_grant;
          req1_ready = w_grant;
          w_accept   = 1'b1;
          w_next     = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == 2'd0) begin
          w_cap  = 1'b1;
          w_next = RESP;
        end
      end
      RESP: begin
        if (r_gid ? rsp1_ready : rsp0_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_gid      <= 1'b0;
      r_cnt      <= 2'd0;
      r_a        <= 4'd0;
      r_b        <= 4'd0;
      r_op       <= 2'b00;
      r_rsp0_r   <= 5'd0;
      r_rsp1_r   <= 5'd0;
      r_rsp0_neg <= 1'b0;
      r_rsp1_neg <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= w_grant ? req1_a  : req0_a;
        r_b    <= w_grant ? req1_b  : req0_b;
        r_op   <= w_grant ? req1_op : req0_op;
        r_gid  <= w_grant;
        r_last <= w_grant;
        r_cnt  <= CNT_INIT;
      end else if (r_state == EXEC && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_cap) begin
        if (r_gid) begin
          r_rsp1_r   <= alu_r;
          r_rsp1_neg <= neg_flag(r_op, alu_neg);
        end else begin
          r_rsp0_r   <= alu_r;
          r_rsp0_neg <= neg_flag(r_op, alu_neg);
        end
      end
    end
  end

  // Operands come straight from the latch so the ALU never sees live requester inputs.
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp0_valid = (r_state == RESP) && !r_gid;
  assign rsp1_valid = (r_state == RESP) && r_gid;
  assign rsp0_r     = r_rsp0_r;
  assign rsp1_r     = r_rsp1_r;
  assign rsp0_neg   = r_rsp0_neg;
  assign rsp1_neg   = r_rsp1_neg;
  assign busy       = (r_state != IDLE);

endmodule
